// File: rtl/alu_arbiter_if.sv
// Request, ALU-bus and response signals shared between the requesters,
// the arbiter and the combinational ALU.
interface alu_arbiter_if;
    // requester side
    logic       req0;
    logic       req1;
    logic [3:0] op0_a;
    logic [3:0] op1_a;
    logic [3:0] op0_b;
    logic [3:0] op1_b;
    logic [1:0] op0_sel;
    logic [1:0] op1_sel;
    logic [1:0] op0_sw;
    logic [1:0] op1_sw;
    logic       gnt0;
    logic       gnt1;
    // ALU bus
    logic [3:0] alu_in1;
    logic [3:0] alu_in2;
    logic [1:0] alu_selector;
    logic       alu_switch1;
    logic       alu_switch2;
    logic [7:0] alu_out;
    // response port
    logic       rsp_valid;
    logic       rsp_id;
    logic [7:0] rsp_data;
    logic       rsp_ready;
    logic       busy;

    // arbiter view
    modport slave (
        input  req0, req1, op0_a, op1_a, op0_b, op1_b,
               op0_sel, op1_sel, op0_sw, op1_sw, alu_out, rsp_ready,
        output gnt0, gnt1, alu_in1, alu_in2, alu_selector,
               alu_switch1, alu_switch2, rsp_valid, rsp_id, rsp_data, busy
    );

    // requester / ALU / consumer view
    modport master (
        output req0, req1, op0_a, op1_a, op0_b, op1_b,
               op0_sel, op1_sel, op0_sw, op1_sw, alu_out, rsp_ready,
        input  gnt0, gnt1, alu_in1, alu_in2, alu_selector,
               alu_switch1, alu_switch2, rsp_valid, rsp_id, rsp_data, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter/sequencer for the 4-bit ALU: grants one
// request at a time, drives the ALU bus, waits SETTLE_CYCLES edges, then
// returns the captured 8-bit result over a valid/ready port.
module alu_arbiter #(
    parameter int unsigned SETTLE_CYCLES = 1  // legal 1..15
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t     state_q,     state_d;
    logic [3:0] cnt_q,       cnt_d;
    logic       last_q,      last_d;
    logic       gnt0_q,      gnt0_d;
    logic       gnt1_q,      gnt1_d;
    logic [3:0] in1_q,       in1_d;
    logic [3:0] in2_q,       in2_d;
    logic [1:0] sel_q,       sel_d;
    logic       sw1_q,       sw1_d;
    logic       sw2_q,       sw2_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic       rsp_id_q,    rsp_id_d;
    logic [7:0] rsp_data_q,  rsp_data_d;
    logic       winner;

    // Next-state: arbitration in IDLE, settle countdown, response handshake.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        in1_d       = in1_q;
        in2_d       = in2_q;
        sel_d       = sel_q;
        sw1_d       = sw1_q;
        sw2_d       = sw2_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        // on a tie the requester not served last wins; otherwise the sole requester
        winner      = (bus.req0 && bus.req1) ? ~last_q : bus.req1;

        unique case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    if (winner) begin
                        gnt1_d = 1'b1;
                        in1_d  = bus.op1_a;
                        in2_d  = bus.op1_b;
                        sel_d  = bus.op1_sel;
                        sw1_d  = bus.op1_sw[0];
                        sw2_d  = bus.op1_sw[1];
                    end else begin
                        gnt0_d = 1'b1;
                        in1_d  = bus.op0_a;
                        in2_d  = bus.op0_b;
                        sel_d  = bus.op0_sel;
                        sw1_d  = bus.op0_sw[0];
                        sw2_d  = bus.op0_sw[1];
                    end
                    last_d  = winner;
                    cnt_d   = 4'(SETTLE_CYCLES);
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                cnt_d = cnt_q - 4'd1;
                // last_q still names the owner of the operation in flight
                if (cnt_q <= 4'd1) begin
                    cnt_d       = '0;
                    rsp_data_d  = bus.alu_out;
                    rsp_id_d    = last_q;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; asynchronous reset aborts any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_q      <= 1'b1;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            in1_q       <= '0;
            in2_q       <= '0;
            sel_q       <= '0;
            sw1_q       <= 1'b0;
            sw2_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            in1_q       <= in1_d;
            in2_q       <= in2_d;
            sel_q       <= sel_d;
            sw1_q       <= sw1_d;
            sw2_q       <= sw2_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign bus.gnt0         = gnt0_q;
    assign bus.gnt1         = gnt1_q;
    assign bus.alu_in1      = in1_q;
    assign bus.alu_in2      = in2_q;
    assign bus.alu_selector = sel_q;
    assign bus.alu_switch1  = sw1_q;
    assign bus.alu_switch2  = sw2_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_id       = rsp_id_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a cycle table on a SETTLE_CYCLES=1
// instance plus hand-written settle and reset-abort sequences on a
// SETTLE_CYCLES=3 instance. ALU model: alu_out = {alu_in1, alu_in2}.
module tb_alu_arbiter;

    logic clk;
    logic rst_n;
    logic zero_b;  // holds instance B's alu_out at 0 to detect early capture

    int checks   = 0;
    int failures = 0;

    alu_arbiter_if ifa ();
    alu_arbiter_if ifb ();

    alu_arbiter #(.SETTLE_CYCLES(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    alu_arbiter #(.SETTLE_CYCLES(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    assign ifa.alu_out = {ifa.alu_in1, ifa.alu_in2};
    assign ifb.alu_out = zero_b ? 8'h00 : {ifb.alu_in1, ifb.alu_in2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       r0;
        logic       r1;
        logic       rdy;
        logic       g0;
        logic       g1;
        logic       busy;
        logic       rv;
        logic       rid;
        logic [7:0] data;
        logic [3:0] in1;
        logic [3:0] in2;
        logic [1:0] sel;
        logic [1:0] sw;
    } vec_t;

    localparam int NVEC = 26;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic r0, input logic r1, input logic rdy,
                                input logic g0, input logic g1, input logic bz,
                                input logic rv, input logic rid, input logic [7:0] data,
                                input logic [3:0] in1, input logic [3:0] in2,
                                input logic [1:0] sel, input logic [1:0] sw);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.rdy = rdy;
        v.g0 = g0; v.g1 = g1; v.busy = bz; v.rv = rv; v.rid = rid;
        v.data = data; v.in1 = in1; v.in2 = in2; v.sel = sel; v.sw = sw;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [24:0] all_out_a();
        return {ifa.gnt0, ifa.gnt1, ifa.alu_in1, ifa.alu_in2, ifa.alu_selector,
                ifa.alu_switch1, ifa.alu_switch2, ifa.rsp_valid, ifa.rsp_id,
                ifa.rsp_data, ifa.busy};
    endfunction

    function automatic logic [24:0] all_out_b();
        return {ifb.gnt0, ifb.gnt1, ifb.alu_in1, ifb.alu_in2, ifb.alu_selector,
                ifb.alu_switch1, ifb.alu_switch2, ifb.rsp_valid, ifb.rsp_id,
                ifb.rsp_data, ifb.busy};
    endfunction

    initial begin
        // op0: A,5,sel 01,sw 00 -> A5 ; op1: 3,C,sel 10,sw 11 -> 3C
        //               r0 r1 rdy g0 g1 bz rv id data   in1   in2   sel    sw
        vecs[0]  = mk(1, 1, 1, 1, 0, 1, 0, 0, 8'h00, 4'hA, 4'h5, 2'b01, 2'b00);
        vecs[1]  = mk(1, 1, 1, 0, 0, 1, 1, 0, 8'hA5, 4'hA, 4'h5, 2'b01, 2'b00);
        vecs[2]  = mk(1, 1, 1, 0, 0, 0, 0, 0, 8'hA5, 4'hA, 4'h5, 2'b01, 2'b00);
        vecs[3]  = mk(1, 1, 1, 0, 1, 1, 0, 0, 8'hA5, 4'h3, 4'hC, 2'b10, 2'b11);
        vecs[4]  = mk(1, 1, 1, 0, 0, 1, 1, 1, 8'h3C, 4'h3, 4'hC, 2'b10, 2'b11);
        vecs[5]  = mk(1, 1, 1, 0, 0, 0, 0, 1, 8'h3C, 4'h3, 4'hC, 2'b10, 2'b11);
        vecs[6]  = mk(1, 1, 1, 1, 0, 1, 0, 1, 8'h3C, 4'hA, 4'h5, 2'b01, 2'b00);
        vecs[7]  = mk(1, 1, 1, 0, 0, 1, 1, 0, 8'hA5, 4'hA, 4'h5, 2'b01, 2'b00);
        vecs[8]  = mk(1, 1, 1, 0, 0, 0, 0, 0, 8'hA5, 4'hA, 4'h5, 2'b01, 2'b00);
        vecs[9]  = mk(1, 1, 1, 0, 1, 1, 0, 0, 8'hA5, 4'h3, 4'hC, 2'b10, 2'b11);
        vecs[10] = mk(1, 1, 1, 0, 0, 1, 1, 1, 8'h3C, 4'h3, 4'hC, 2'b10, 2'b11);
        vecs[11] = mk(1, 1, 1, 0, 0, 0, 0, 1, 8'h3C, 4'h3, 4'hC, 2'b10, 2'b11);
        // backpressure with req1 pending
        vecs[12] = mk(1, 0, 0, 1, 0, 1, 0, 1, 8'h3C, 4'hA, 4'h5, 2'b01, 2'b00);
        vecs[13] = mk(0, 1, 0, 0, 0, 1, 1, 0, 8'hA5, 4'hA, 4'h5, 2'b01, 2'b00);
        vecs[14] = mk(0, 1, 0, 0, 0, 1, 1, 0, 8'hA5, 4'hA, 4'h5, 2'b01, 2'b00);
        vecs[15] = mk(0, 1, 0, 0, 0, 1, 1, 0, 8'hA5, 4'hA, 4'h5, 2'b01, 2'b00);
        vecs[16] = mk(0, 1, 0, 0, 0, 1, 1, 0, 8'hA5, 4'hA, 4'h5, 2'b01, 2'b00);
        vecs[17] = mk(0, 1, 0, 0, 0, 1, 1, 0, 8'hA5, 4'hA, 4'h5, 2'b01, 2'b00);
        vecs[18] = mk(0, 1, 1, 0, 0, 0, 0, 0, 8'hA5, 4'hA, 4'h5, 2'b01, 2'b00);
        vecs[19] = mk(0, 1, 1, 0, 1, 1, 0, 0, 8'hA5, 4'h3, 4'hC, 2'b10, 2'b11);
        vecs[20] = mk(0, 0, 1, 0, 0, 1, 1, 1, 8'h3C, 4'h3, 4'hC, 2'b10, 2'b11);
        vecs[21] = mk(0, 0, 1, 0, 0, 0, 0, 1, 8'h3C, 4'h3, 4'hC, 2'b10, 2'b11);
        // req1 loses a tie, then withdraws before being granted
        vecs[22] = mk(1, 1, 1, 1, 0, 1, 0, 1, 8'h3C, 4'hA, 4'h5, 2'b01, 2'b00);
        vecs[23] = mk(0, 0, 1, 0, 0, 1, 1, 0, 8'hA5, 4'hA, 4'h5, 2'b01, 2'b00);
        vecs[24] = mk(0, 0, 1, 0, 0, 0, 0, 0, 8'hA5, 4'hA, 4'h5, 2'b01, 2'b00);
        vecs[25] = mk(0, 0, 1, 0, 0, 0, 0, 0, 8'hA5, 4'hA, 4'h5, 2'b01, 2'b00);

        rst_n  = 1'b0;
        zero_b = 1'b0;
        ifa.req0 = 1'b1; ifa.req1 = 1'b1; ifa.rsp_ready = 1'b1;
        ifa.op0_a = 4'hA; ifa.op0_b = 4'h5; ifa.op0_sel = 2'b01; ifa.op0_sw = 2'b00;
        ifa.op1_a = 4'h3; ifa.op1_b = 4'hC; ifa.op1_sel = 2'b10; ifa.op1_sw = 2'b11;
        ifb.req0 = 1'b0; ifb.req1 = 1'b0; ifb.rsp_ready = 1'b1;
        ifb.op0_a = 4'hA; ifb.op0_b = 4'h5; ifb.op0_sel = 2'b01; ifb.op0_sw = 2'b00;
        ifb.op1_a = 4'h3; ifb.op1_b = 4'hC; ifb.op1_sel = 2'b10; ifb.op1_sw = 2'b11;

        repeat (2) @(negedge clk);
        check("reset_a_outputs", 32'(all_out_a()), 32'h0);
        check("reset_b_outputs", 32'(all_out_b()), 32'h0);
        rst_n = 1'b1;

        // cycle table on instance A; row i = inputs seen at edge i+1, outputs after it
        for (int i = 0; i < NVEC; i++) begin
            ifa.req0      = vecs[i].r0;
            ifa.req1      = vecs[i].r1;
            ifa.rsp_ready = vecs[i].rdy;
            @(negedge clk);
            check($sformatf("row%0d_gnt", i), 32'({ifa.gnt0, ifa.gnt1}),
                  32'({vecs[i].g0, vecs[i].g1}));
            check($sformatf("row%0d_busy", i), 32'(ifa.busy), 32'(vecs[i].busy));
            check($sformatf("row%0d_rsp", i), 32'({ifa.rsp_valid, ifa.rsp_id, ifa.rsp_data}),
                  32'({vecs[i].rv, vecs[i].rid, vecs[i].data}));
            check($sformatf("row%0d_alu", i),
                  32'({ifa.alu_in1, ifa.alu_in2, ifa.alu_selector, ifa.alu_switch2, ifa.alu_switch1}),
                  32'({vecs[i].in1, vecs[i].in2, vecs[i].sel, vecs[i].sw}));
        end

        // settle window on instance B: alu_out is 0 through edge k+2
        ifb.req0 = 1'b1;
        zero_b   = 1'b1;
        @(negedge clk);  // after edge k
        check("settle_grant", 32'({ifb.gnt0, ifb.gnt1, ifb.busy, ifb.rsp_valid}), 32'b1010);
        check("settle_alu", 32'({ifb.alu_in1, ifb.alu_in2, ifb.alu_selector}), 32'({4'hA, 4'h5, 2'b01}));
        ifb.req0 = 1'b0;
        @(negedge clk);  // after k+1
        check("settle_k1", 32'({ifb.gnt0, ifb.busy, ifb.rsp_valid}), 32'b010);
        @(negedge clk);  // after k+2
        check("settle_k2", 32'({ifb.busy, ifb.rsp_valid}), 32'b10);
        zero_b = 1'b0;
        @(negedge clk);  // after k+3
        check("settle_k3_rsp", 32'({ifb.rsp_valid, ifb.rsp_id, ifb.rsp_data}), 32'({1'b1, 1'b0, 8'hA5}));
        @(negedge clk);  // handshake at k+4
        check("settle_done", 32'({ifb.busy, ifb.rsp_valid, ifb.rsp_data}), 32'({1'b0, 1'b0, 8'hA5}));

        // reset pulsed mid-cycle: A holds a response, B is mid-settle
        ifa.req1 = 1'b1;
        ifb.req0 = 1'b1;
        @(negedge clk);
        check("abort_grants", 32'({ifa.gnt1, ifb.gnt0}), 32'b11);
        ifa.req1 = 1'b0;
        ifb.req0 = 1'b0;
        @(posedge clk);
        #2;
        check("abort_pre_a_valid", 32'({ifa.rsp_valid, ifa.rsp_id, ifa.rsp_data}), 32'({1'b1, 1'b1, 8'h3C}));
        check("abort_pre_b_busy", 32'({ifb.busy, ifb.rsp_valid}), 32'b10);
        rst_n = 1'b0;
        #1;
        check("async_reset_a", 32'(all_out_a()), 32'h0);
        check("async_reset_b", 32'(all_out_b()), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("abort_quiet%0d", i),
                  32'({ifa.rsp_valid, ifa.busy, ifa.gnt0, ifa.gnt1,
                       ifb.rsp_valid, ifb.busy, ifb.gnt0, ifb.gnt1}), 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
